// File: rtl/pe_opsum_arbiter.sv
// Round-robin arbiter sharing the single GLB write port among NUM_PE PEs draining opsums.
// A granted PE keeps the port for its whole burst; each PE writes a contiguous GLB region
// starting at base + pe*(len+1).
// Optional: define OPSUM_RELU_EN to clamp negative opsums to zero on the way to the GLB.
module pe_opsum_arbiter #(
  parameter int unsigned NUM_PE = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned ID_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [5:0]               cfg_len,
  input  logic [ADDR_W-1:0]        cfg_base,
  input  logic [NUM_PE-1:0]        pe_opsum_enable,
  input  logic [NUM_PE*DATA_W-1:0] pe_opsum,
  output logic [NUM_PE-1:0]        pe_opsum_ready,
  input  logic                     glb_ready,
  output logic                     glb_wen,
  output logic [ADDR_W-1:0]        glb_addr,
  output logic [DATA_W-1:0]        glb_wdata,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy,
  output logic                     all_done
);

  typedef enum logic [1:0] {StIdle, StArb, StXfer, StDone} state_e;

  state_e              state_q, state_d;
  logic [5:0]          len_q, beat_q;
  logic [ADDR_W-1:0]   base_q;
  logic [ID_W-1:0]     grant_q, rr_q;
  logic [NUM_PE-1:0]   done_q;

  logic                cand_vld;
  logic [ID_W-1:0]     cand_id;
  logic [NUM_PE-1:0]   grant_mask;
  logic                sel_en;
  logic [DATA_W-1:0]   sel_data;
  logic                beat, last_beat, all_fin;
  logic [ID_W-1:0]     rr_nxt;

  assign grant_mask = NUM_PE'(1) << grant_q;
  assign sel_en     = |(pe_opsum_enable & grant_mask);
  assign beat       = (state_q == StXfer) && sel_en && glb_ready;
  assign last_beat  = beat && (beat_q == len_q);
  assign all_fin    = &(done_q | grant_mask);
  assign rr_nxt     = (grant_q == ID_W'(NUM_PE - 1)) ? '0 : grant_q + 1'b1;
  assign grant_id   = grant_q;

  // Pick the first requesting, not-yet-finished PE at or after rr_q (circular scan).
  always_comb begin
    logic [ID_W:0]     p;
    logic [NUM_PE-1:0] avail_sh;
    cand_vld = 1'b0;
    cand_id  = '0;
    p        = '0;
    avail_sh = '0;
    for (int unsigned k = 0; k < NUM_PE; k++) begin
      p = {1'b0, rr_q} + (ID_W + 1)'(k);
      if (p >= (ID_W + 1)'(NUM_PE)) p = p - (ID_W + 1)'(NUM_PE);
      avail_sh = (pe_opsum_enable & ~done_q) >> p;
      if (!cand_vld && avail_sh[0]) begin
        cand_vld = 1'b1;
        cand_id  = p[ID_W-1:0];
      end
    end
  end

  // Mux out the granted PE's opsum.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_PE; i++) begin
      if (grant_q == ID_W'(i)) sel_data = pe_opsum[i*DATA_W +: DATA_W];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic; start is only honoured when no pass is running.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StArb;
      StArb:          if (cand_vld) state_d = StXfer;
      StXfer:         if (last_beat) state_d = all_fin ? StDone : StArb;
      default:        state_d = StIdle;
    endcase
  end

  // Pass configuration, grant, beat counter, done flags and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q   <= '0;
      base_q  <= '0;
      done_q  <= '0;
      grant_q <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
    end else begin
      if ((state_q == StIdle || state_q == StDone) && start) begin
        len_q  <= cfg_len;
        base_q <= cfg_base;
        done_q <= '0;
      end
      if (state_q == StArb && cand_vld) begin
        grant_q <= cand_id;
        beat_q  <= '0;
      end
      if (beat) begin
        beat_q <= beat_q + 1'b1;
        if (last_beat) begin
          done_q <= done_q | grant_mask;
          rr_q   <= rr_nxt;
        end
      end
    end
  end

  // Outputs: the write port is only driven while a PE holds the grant.
  always_comb begin
    pe_opsum_ready = '0;
    glb_wen        = 1'b0;
    glb_addr       = '0;
    glb_wdata      = '0;
    busy           = (state_q == StArb) || (state_q == StXfer);
    all_done       = (state_q == StDone);
    if (state_q == StXfer) begin
      pe_opsum_ready = glb_ready ? grant_mask : '0;
      glb_wen        = beat;
      // Modular ADDR_W arithmetic gives the required wrap-around.
      glb_addr       = base_q + ADDR_W'(grant_q) * (ADDR_W'(len_q) + ADDR_W'(1))
                       + ADDR_W'(beat_q);
`ifdef OPSUM_RELU_EN
      glb_wdata      = sel_data[DATA_W-1] ? '0 : sel_data;
`else
      glb_wdata      = sel_data;
`endif
    end
  end

endmodule

// File: tb/tb_pe_opsum_arbiter.sv
// Self-checking bench for pe_opsum_arbiter: directed scenarios followed by random traffic,
// compared each cycle against a transaction-level model of the drain pass.
module tb_pe_opsum_arbiter;
  localparam int NP = 4;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [5:0]      cfg_len;
  logic [AW-1:0]   cfg_base;
  logic [NP-1:0]   pe_opsum_enable;
  logic [NP*DW-1:0] pe_opsum;
  logic [NP-1:0]   pe_opsum_ready;
  logic            glb_ready;
  logic            glb_wen;
  logic [AW-1:0]   glb_addr;
  logic [DW-1:0]   glb_wdata;
  logic [IW-1:0]   grant_id;
  logic            busy;
  logic            all_done;

  pe_opsum_arbiter #(.NUM_PE(NP), .DATA_W(DW), .ADDR_W(AW), .ID_W(IW)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .cfg_len         (cfg_len),
    .cfg_base        (cfg_base),
    .pe_opsum_enable (pe_opsum_enable),
    .pe_opsum        (pe_opsum),
    .pe_opsum_ready  (pe_opsum_ready),
    .glb_ready       (glb_ready),
    .glb_wen         (glb_wen),
    .glb_addr        (glb_addr),
    .glb_wdata       (glb_wdata),
    .grant_id        (grant_id),
    .busy            (busy),
    .all_done        (all_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model of a drain pass.
  bit m_active;      // pass running (arbitrating or transferring)
  bit m_all_done;
  int m_owner;       // PE holding the port, -1 while arbitrating
  int m_grant;       // last PE granted (what grant_id shows)
  int m_next;        // first PE to consider at the next arbitration
  int m_delivered;   // beats delivered by the current owner
  bit m_done[NP];
  int m_len;
  int m_base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_all_done = 0; m_owner = -1; m_grant = 0; m_next = 0;
    m_delivered = 0; m_len = 0; m_base = 0;
    for (int i = 0; i < NP; i++) m_done[i] = 0;
  endtask

  task automatic check_outputs();
    bit xf;
    logic [NP-1:0] e_ready;
    logic e_wen;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    xf = m_active && (m_owner >= 0);
    e_ready = '0; e_wen = 0; e_addr = '0; e_data = '0;
    if (xf) begin
      if (glb_ready) e_ready[m_owner] = 1'b1;
      e_wen  = pe_opsum_enable[m_owner] && glb_ready;
      e_addr = AW'(m_base + m_owner * (m_len + 1) + m_delivered);
      e_data = pe_opsum[m_owner*DW +: DW];
`ifdef OPSUM_RELU_EN
      if (e_data[DW-1]) e_data = '0;
`endif
    end
    check("ready", 32'(pe_opsum_ready), 32'(e_ready));
    check("wen", 32'(glb_wen), 32'(e_wen));
    check("addr", 32'(glb_addr), 32'(e_addr));
    check("wdata", glb_wdata, e_data);
    check("grant_id", 32'(grant_id), 32'(m_grant));
    check("busy", 32'(busy), 32'(m_active));
    check("all_done", 32'(all_done), 32'(m_all_done));
  endtask

  task automatic model_step();
    bit fin;
    if (start && !m_active) begin
      m_active = 1; m_all_done = 0; m_owner = -1;
      m_len = int'(cfg_len); m_base = int'(cfg_base);
      for (int i = 0; i < NP; i++) m_done[i] = 0;
    end else if (m_active && m_owner < 0) begin
      for (int d = 0; d < NP; d++) begin
        int p;
        p = (m_next + d) % NP;
        if (m_owner < 0 && pe_opsum_enable[p] && !m_done[p]) begin
          m_owner = p; m_grant = p; m_delivered = 0;
        end
      end
    end else if (m_active && pe_opsum_enable[m_owner] && glb_ready) begin
      m_delivered++;
      if (m_delivered == m_len + 1) begin
        m_done[m_owner] = 1;
        m_next = (m_owner + 1) % NP;
        m_owner = -1;
        fin = 1;
        for (int i = 0; i < NP; i++) if (!m_done[i]) fin = 0;
        if (fin) begin m_active = 0; m_all_done = 1; end
      end
    end
  endtask

  // One clock: drive at negedge, check combinational outputs, update model at posedge.
  task automatic cycle(input bit st, input logic [5:0] len, input logic [AW-1:0] base,
                       input logic [NP-1:0] en, input bit rdy);
    @(negedge clk);
    start = st; cfg_len = len; cfg_base = base; pe_opsum_enable = en; glb_ready = rdy;
    pe_opsum = {$urandom, $urandom, $urandom, $urandom};
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
  endtask

  initial begin
    rst = 1; start = 0; cfg_len = '0; cfg_base = '0; pe_opsum_enable = '0;
    pe_opsum = '0; glb_ready = 0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk); @(negedge clk);
    rst = 0;

    // All PEs at once, one beat each: grant order 0..3, then all_done.
    cycle(1, 6'd0, 8'h20, 4'b1111, 1);
    repeat (9) cycle(0, 6'd0, 8'h00, 4'b1111, 1);
    check("pass1_done", 32'(all_done), 32'd1);

    // Only PE2 requests: three consecutive writes at 0x16..0x18, no all_done.
    cycle(1, 6'd2, 8'h10, 4'b0100, 1);
    repeat (6) cycle(0, 6'd0, 8'h00, 4'b0100, 1);
    check("pe2_only_busy", 32'(busy), 32'd1);
    // PE0 and PE2 re-request: PE2 is done and must stay ungranted; then the rest.
    repeat (6) cycle(0, 6'd0, 8'h00, 4'b0101, 1);
    repeat (14) cycle(0, 6'd0, 8'h00, 4'b1111, 1);

    // Backpressure and grant lock on a 4-beat burst with PE1 also requesting.
    cycle(1, 6'd3, 8'hF0, 4'b0011, 1);
    cycle(0, 6'd0, 8'h00, 4'b0011, 1);
    cycle(0, 6'd0, 8'h00, 4'b0011, 1);
    cycle(0, 6'd0, 8'h00, 4'b0011, 0);
    cycle(0, 6'd0, 8'h00, 4'b0010, 1);
    cycle(0, 6'd0, 8'h00, 4'b0010, 1);
    repeat (8) cycle(0, 6'd0, 8'h00, 4'b0011, 1);

    // Reset in the middle of a burst, then a fresh pass starts at PE0.
    repeat (3) cycle(0, 6'd0, 8'h00, 4'b1111, 1);
    @(negedge clk);
    #2 rst = 1;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    rst = 0;
    cycle(1, 6'd1, 8'h08, 4'b1111, 1);
    cycle(0, 6'd0, 8'h00, 4'b1111, 1);
    check("restart_grant", 32'(grant_id), 32'd0);
    repeat (8) cycle(0, 6'd0, 8'h00, 4'b1111, 1);

    // Random traffic with random backpressure and occasional start while busy.
    for (int n = 0; n < 1500; n++) begin
      bit st;
      st = (!m_active && $urandom_range(0, 3) == 0) || ($urandom_range(0, 30) == 0);
      cycle(st, 6'($urandom_range(0, 5)), AW'($urandom), NP'($urandom),
            $urandom_range(0, 3) != 0);
      if (n == 777) begin
        @(negedge clk);
        #2 rst = 1;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        rst = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pe_opsum_arbiter.md
Name: pe_opsum_arbiter

Overview:
- Shares the single global-buffer (GLB) write port among NUM_PE processing elements that drain output partial sums.
- Uses each PE's opsum_enable/opsum_ready handshake.
- Grants one PE at a time, round-robin, and locks the grant for that PE's whole opsum burst. Each PE's opsums go to a contiguous GLB region.
- Sits between the PE array and the GLB. It is sequenced by a top-level layer controller through start/all_done.

Parameters:
- NUM_PE, 4, number of PEs arbitrated (2..8)
- DATA_W, 32, opsum width in bits
- ADDR_W, 8, GLB address width
- ID_W, 2, width of the grant index (must satisfy 2^ID_W >= NUM_PE)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse that begins a drain pass; latches cfg_len and cfg_base
- cfg_len  in  6  beats per PE minus 1 (1..64 beats)
- cfg_base  in  ADDR_W  GLB base address of PE 0's region
- pe_opsum_enable  in  NUM_PE  per-PE valid; bit i belongs to PE i
- pe_opsum  in  NUM_PE*DATA_W  per-PE data; PE i occupies bits [i*DATA_W +: DATA_W]
- pe_opsum_ready  out  NUM_PE  per-PE ready
- glb_ready  in  1  GLB can accept a write this cycle
- glb_wen  out  1  GLB write strobe
- glb_addr  out  ADDR_W  GLB write address
- glb_wdata  out  DATA_W  GLB write data
- grant_id  out  ID_W  currently granted PE
- busy  out  1  a pass is in progress
- all_done  out  1  every PE has delivered its burst

Behaviour:
- Reset values:
  - state=IDLE; rr_ptr=0; grant_id=0; beat_cnt=0; done_flags=0; latched cfg=0.
  - All outputs are 0.
- States and transitions:
  - IDLE: start moves to ARB; latch cfg_len→len_q and cfg_base→base_q; clear done_flags.
  - ARB: scan PEs in order rr_ptr, rr_ptr+1, … (mod NUM_PE). Pick the first with pe_opsum_enable=1 and done_flags bit=0. Register it into grant_id, clear beat_cnt, go to XFER next cycle. If no candidate, stay in ARB.
  - XFER: a beat happens when pe_opsum_enable[grant_id] && glb_ready. Each beat increments beat_cnt.
    - On the beat where beat_cnt==len_q: set done_flags[grant_id] and set rr_ptr=(grant_id+1) mod NUM_PE.
    - Then go to DONE if all done_flags are set, otherwise ARB.
  - DONE: all_done=1. A start pulse returns to ARB with a fresh latch and done_flags cleared.
- Combinational outputs, zero latency, valid in XFER only:
  - pe_opsum_ready[grant_id] = glb_ready. All other ready bits are 0.
  - glb_wen = pe_opsum_enable[grant_id] && glb_ready.
  - glb_wdata = pe_opsum slice of grant_id.
  - glb_addr = base_q + grant_id*(len_q+1) + beat_cnt, truncated to ADDR_W (wraps modulo 2^ADDR_W).
- Outside XFER: glb_wen=0, all pe_opsum_ready=0, glb_addr/glb_wdata=0.
- busy=1 in ARB and XFER.
- Grant lock:
  - Once granted, a PE keeps the port until its last beat, even if it deasserts enable mid-burst; this inserts stall cycles with no write.
  - Other PEs' enables are ignored during the lock.
- Simultaneous events:
  - start while busy is ignored.
  - glb_ready=0 holds all counters and state.
  - An enable from a PE whose done flag is set is never granted.
- rst asserted mid-pass returns immediately to reset values. Beats in flight are dropped and no write is issued.

Optional Feature:
- Macro OPSUM_RELU_EN.
- Defined: glb_wdata passes through ReLU. If the granted opsum's MSB is 1 (signed negative), 0 is written; otherwise the value is written unchanged. Timing and handshake are unaffected.
- Undefined: data is written unmodified.

Test Plan:
- Single PE: NUM_PE=4, cfg_len=2, cfg_base=0x10, only PE2 enabled, glb_ready=1 → 3 writes to 0x16,0x17,0x18 on consecutive XFER cycles; PE2 done; no all_done.
- All four PEs enabled together, cfg_len=0 → grant order 0,1,2,3; addresses base+0..base+3; all_done=1 after the 4th write; busy falls the same cycle.
- Round-robin fairness: PE0 finishes, PE0 and PE3 re-request → PE0 never regranted in the pass; PE3 is granted next.
- Backpressure: glb_ready toggles 1,0,1 during PE1's burst → beat_cnt and addr hold on the 0 cycle; no duplicate or lost write; pe_opsum_ready[1] mirrors glb_ready.
- Grant lock: PE0 drops enable after beat 1 of 4 while PE1 is requesting → stall with glb_wen=0; PE1 is not granted until PE0's 4th beat.
- Reset mid-XFER: rst pulse after 2 beats → all outputs 0 asynchronously; new start restarts at PE0 with beat_cnt 0.
